// File: rtl/psum_mem_pkg.sv
// Shared constants and types for the ping-pong partial-sum memory.
package psum_mem_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 1024;

    // Index of one of the two ping-pong banks.
    typedef logic bank_sel_t;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

endpackage

// File: rtl/psum_acc_channel.sv
// One psum channel: two banks, accumulate pipeline with forwarding,
// and the AXI read/clear path on the bank not being written.
module psum_acc_channel
    import psum_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_bank,
    input  logic              ctrl_we,
    input  logic              ctrl_acc,
    input  logic [ADDR_W-1:0] ctrl_addr,
    input  logic [DATA_W-1:0] ctrl_din,
    input  logic              axi_rd_en,
    input  logic              axi_clr,
    input  logic [ADDR_W-1:0] axi_addr,
    output logic [DATA_W-1:0] axi_dout,
    output logic              axi_dout_vld,
    output logic              s1_vld
);

    logic              s1_acc;
    logic              s1_fwd;
    bank_sel_t         s1_bank;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_din;
    logic [DATA_W-1:0] last_sum;
    logic [DATA_W-1:0] s1_operand;
    logic [DATA_W-1:0] s1_sum;

    logic              ax1_vld;
    logic              ax1_clr;
    logic              ax1_zero;
    bank_sel_t         ax1_bank;
    logic [ADDR_W-1:0] ax1_addr;
    logic [DATA_W-1:0] ax1_rd;

    // The previous op's write lands in the same edge as this op's RAM read,
    // so a same-address follower takes the registered sum instead.
    assign s1_operand = s1_fwd ? last_sum
                               : (s1_bank ? g_bank[1].rd_q : g_bank[0].rd_q);
    assign s1_sum     = s1_acc ? s1_operand + s1_din : s1_din;
    assign ax1_rd     = ax1_bank ? g_bank[1].rd_q : g_bank[0].rd_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic [ADDR_W-1:0] rd_addr;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;

        // Accumulate and clear writes never target the same bank in one cycle.
        always_comb begin
            rd_addr = (wr_bank == 1'(b)) ? ctrl_addr : axi_addr;
            we      = 1'b0;
            wa      = s1_addr;
            wd      = s1_sum;
            if (s1_vld && (s1_bank == 1'(b))) begin
                we = 1'b1;
            end else if (ax1_vld && ax1_clr && (ax1_bank == 1'(b))) begin
                we = 1'b1;
                wa = ax1_addr;
                wd = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (we) mem[wa] <= wd;
            rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld       <= 1'b0;
            s1_acc       <= 1'b0;
            s1_fwd       <= 1'b0;
            s1_bank      <= 1'b0;
            s1_addr      <= '0;
            s1_din       <= '0;
            last_sum     <= '0;
            ax1_vld      <= 1'b0;
            ax1_clr      <= 1'b0;
            ax1_zero     <= 1'b0;
            ax1_bank     <= 1'b0;
            ax1_addr     <= '0;
            axi_dout     <= '0;
            axi_dout_vld <= 1'b0;
        end else begin
            s1_vld <= ctrl_we;
            if (ctrl_we) begin
                s1_acc  <= ctrl_acc;
                s1_addr <= ctrl_addr;
                s1_din  <= ctrl_din;
                s1_bank <= wr_bank;
                s1_fwd  <= s1_vld && (s1_addr == ctrl_addr);
            end
            if (s1_vld) last_sum <= s1_sum;

            ax1_vld <= axi_rd_en;
            if (axi_rd_en) begin
                ax1_clr  <= axi_clr;
                ax1_addr <= axi_addr;
                ax1_bank <= ~wr_bank;
                // A read right behind a clear of the same word sees the zero.
                ax1_zero <= ax1_vld && ax1_clr && (ax1_addr == axi_addr)
                            && (ax1_bank == ~wr_bank);
            end

            axi_dout_vld <= ax1_vld;
            if (ax1_vld) axi_dout <= ax1_zero ? '0 : ax1_rd;
        end
    end

endmodule

// File: rtl/psum_pingpong_mem.sv
// Multi-channel ping-pong psum memory: per-channel accumulate banks plus the
// shared swap controller that flips which bank the controller writes.
module psum_pingpong_mem
    import psum_mem_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ctrl_we,
    input  logic [NUM_CH-1:0]        ctrl_acc,
    input  logic [NUM_CH*ADDR_W-1:0] ctrl_addr,
    input  logic [NUM_CH*DATA_W-1:0] ctrl_din,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     busy,
    output logic                     wr_bank,
    input  logic [NUM_CH-1:0]        axi_rd_en,
    input  logic [NUM_CH-1:0]        axi_clr,
    input  logic [NUM_CH*ADDR_W-1:0] axi_addr,
    output logic [NUM_CH*DATA_W-1:0] axi_dout,
    output logic [NUM_CH-1:0]        axi_dout_vld
);

    swap_state_t       state;
    logic [NUM_CH-1:0] s1_vld;
    logic              swap_go;

    // Swap only once no write op is being accepted or committed anywhere.
    assign swap_go = (state == SWAP_PENDING) && !(|s1_vld) && !(|ctrl_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SWAP_IDLE;
            wr_bank  <= 1'b0;
            swap_ack <= 1'b0;
            busy     <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                SWAP_IDLE: begin
                    if (swap_req) begin
                        state <= SWAP_PENDING;
                        busy  <= 1'b1;
                    end
                end
                SWAP_PENDING: begin
                    if (swap_go) begin
                        state    <= SWAP_IDLE;
                        busy     <= 1'b0;
                        swap_ack <= 1'b1;
                        wr_bank  <= ~wr_bank;
                    end
                end
                default: state <= SWAP_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        psum_acc_channel #(
            .DATA_W(DATA_W),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_bank     (wr_bank),
            .ctrl_we     (ctrl_we[c]),
            .ctrl_acc    (ctrl_acc[c]),
            .ctrl_addr   (ctrl_addr[c*ADDR_W +: ADDR_W]),
            .ctrl_din    (ctrl_din[c*DATA_W +: DATA_W]),
            .axi_rd_en   (axi_rd_en[c]),
            .axi_clr     (axi_clr[c]),
            .axi_addr    (axi_addr[c*ADDR_W +: ADDR_W]),
            .axi_dout    (axi_dout[c*DATA_W +: DATA_W]),
            .axi_dout_vld(axi_dout_vld[c]),
            .s1_vld      (s1_vld[c])
        );
    end

endmodule

// File: tb/tb_psum_pingpong_mem.sv
// Directed bench for psum_pingpong_mem: accumulate, forwarding, wrap,
// clear-on-read, swap deferral and reset, with a per-channel read scoreboard.
module tb_psum_pingpong_mem;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ctrl_we;
    logic [NUM_CH-1:0]        ctrl_acc;
    logic [NUM_CH*ADDR_W-1:0] ctrl_addr;
    logic [NUM_CH*DATA_W-1:0] ctrl_din;
    logic                     swap_req;
    logic                     swap_ack;
    logic                     busy;
    logic                     wr_bank;
    logic [NUM_CH-1:0]        axi_rd_en;
    logic [NUM_CH-1:0]        axi_clr;
    logic [NUM_CH*ADDR_W-1:0] axi_addr;
    logic [NUM_CH*DATA_W-1:0] axi_dout;
    logic [NUM_CH-1:0]        axi_dout_vld;

    psum_pingpong_mem #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_we     (ctrl_we),
        .ctrl_acc    (ctrl_acc),
        .ctrl_addr   (ctrl_addr),
        .ctrl_din    (ctrl_din),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .busy        (busy),
        .wr_bank     (wr_bank),
        .axi_rd_en   (axi_rd_en),
        .axi_clr     (axi_clr),
        .axi_addr    (axi_addr),
        .axi_dout    (axi_dout),
        .axi_dout_vld(axi_dout_vld)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    int                exp_t [NUM_CH][$];
    logic              wb_exp;
    logic [DATA_W-1:0] model [4];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Each request is due exactly two cycles after issue; vld must be low otherwise.
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (exp_t[c].size() > 0 && exp_t[c][0] == cyc) begin
                check($sformatf("vld_ch%0d", c), 64'(axi_dout_vld[c]), 64'd1);
                check($sformatf("dout_ch%0d", c), axi_dout[c*DATA_W +: DATA_W], exp_q[c][0]);
                void'(exp_q[c].pop_front());
                void'(exp_t[c].pop_front());
            end else begin
                check($sformatf("idle_vld_ch%0d", c), 64'(axi_dout_vld[c]), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int addr, input logic [DATA_W-1:0] din,
                      input logic acc);
        ctrl_we[ch]                       = 1'b1;
        ctrl_acc[ch]                      = acc;
        ctrl_addr[ch*ADDR_W +: ADDR_W]    = ADDR_W'(addr);
        ctrl_din[ch*DATA_W +: DATA_W]     = din;
        tick();
        ctrl_we  = '0;
        ctrl_acc = '0;
    endtask

    task automatic rd(input int ch, input int addr, input logic clr,
                      input logic [DATA_W-1:0] expv);
        axi_rd_en[ch]                  = 1'b1;
        axi_clr[ch]                    = clr;
        axi_addr[ch*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
        exp_q[ch].push_back(expv);
        exp_t[ch].push_back(cyc + 2);
        tick();
        axi_rd_en = '0;
        axi_clr   = '0;
    endtask

    task automatic do_swap();
        int n;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("busy_after_req", 64'(busy), 64'd1);
        wb_exp = ~wb_exp;
        n = 0;
        while (swap_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("swap_ack_seen", 64'(swap_ack), 64'd1);
        check("wr_bank_after_swap", 64'(wr_bank), 64'(wb_exp));
        check("busy_clear", 64'(busy), 64'd0);
        tick();
        check("swap_ack_one_cycle", 64'(swap_ack), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DATA_W-1:0] d;
        logic              acc;
        int                a;

        rst_n     = 1'b1;
        ctrl_we   = '0;
        ctrl_acc  = '0;
        ctrl_addr = '0;
        ctrl_din  = '0;
        swap_req  = 1'b0;
        axi_rd_en = '0;
        axi_clr   = '0;
        axi_addr  = '0;
        wb_exp    = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (3) tick();

        check("rst_wr_bank", 64'(wr_bank), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_swap_ack", 64'(swap_ack), 64'd0);
        check("rst_vld", 64'(axi_dout_vld), 64'd0);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("rst_dout_ch%0d", c), axi_dout[c*DATA_W +: DATA_W], 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Plain overwrite, swap, read back with two-cycle latency.
        wr(0, 5, 64'h10, 1'b0);
        do_swap();
        rd(0, 5, 1'b0, 64'h10);

        // Back-to-back accumulation (forwarded) and a spaced accumulation.
        wr(1, 3, 64'd1, 1'b0);
        wr(1, 3, 64'd2, 1'b1);
        wr(1, 3, 64'd3, 1'b1);
        wr(1, 4, 64'd5, 1'b0);
        tick();
        wr(1, 4, 64'd7, 1'b1);
        do_swap();
        rd(1, 3, 1'b0, 64'd6);
        rd(1, 4, 1'b0, 64'd12);

        // Modulo wrap.
        wr(2, 9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wr(2, 9, 64'd2, 1'b1);
        do_swap();
        rd(2, 9, 1'b0, 64'd1);

        // Clear-on-read, immediate re-read, later re-read, output hold.
        wr(0, 7, 64'h55, 1'b0);
        wr(0, 8, 64'h77, 1'b0);
        do_swap();
        rd(0, 7, 1'b1, 64'h55);
        rd(0, 7, 1'b0, 64'h0);
        repeat (2) tick();
        rd(0, 7, 1'b0, 64'h0);
        rd(0, 8, 1'b0, 64'h77);
        repeat (4) tick();
        check("dout_hold_ch0", axi_dout[DATA_W-1:0], 64'h77);

        // Random accumulate mix on ch2, addresses 0..3, against a small model.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            model[i] = d;
            wr(2, i, d, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            a   = $urandom_range(0, 3);
            acc = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            model[a] = acc ? model[a] + d : d;
            wr(2, a, d, acc);
            if ($urandom_range(0, 3) == 0) tick();
        end
        do_swap();
        for (int i = 0; i < 4; i++) rd(2, i, 1'b0, model[i]);

        // Swap requested inside a write burst; reads straddle the swap.
        wr(0, 20, 64'hA0, 1'b0);
        swap_req = 1'b1;
        wr(0, 21, 64'hA1, 1'b0);
        swap_req = 1'b0;
        check("burst_busy", 64'(busy), 64'd1);
        wr(0, 22, 64'hA2, 1'b0);
        check("burst_no_ack_w3", 64'(swap_ack), 64'd0);
        swap_req = 1'b1;
        wr(0, 23, 64'hA3, 1'b0);
        swap_req = 1'b0;
        check("burst_no_ack_s1", 64'(swap_ack), 64'd0);
        check("burst_busy_s1", 64'(busy), 64'd1);
        rd(2, 9, 1'b0, 64'd1);
        check("burst_no_ack_m", 64'(swap_ack), 64'd0);
        check("burst_busy_m", 64'(busy), 64'd1);
        rd(2, 0, 1'b0, model[0]);
        wb_exp = ~wb_exp;
        check("burst_ack", 64'(swap_ack), 64'd1);
        check("burst_wr_bank", 64'(wr_bank), 64'(wb_exp));
        check("burst_busy_clear", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_extra_ack", 64'(swap_ack), 64'd0);
        end
        for (int i = 0; i < 4; i++) rd(0, 20 + i, 1'b0, 64'hA0 + 64'(i));

        // Reset mid-burst with a swap pending; committed words survive.
        do_swap();
        wr(1, 40, 64'hAB, 1'b0);
        repeat (2) tick();
        wr(1, 41, 64'hC1, 1'b0);
        swap_req = 1'b1;
        wr(1, 42, 64'hC2, 1'b0);
        swap_req = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        ctrl_we[1]                 = 1'b1;
        ctrl_addr[ADDR_W +: ADDR_W] = ADDR_W'(43);
        axi_rd_en[0]               = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_bank", 64'(wr_bank), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_swap_ack", 64'(swap_ack), 64'd0);
        check("mid_rst_vld", 64'(axi_dout_vld), 64'd0);
        ctrl_we   = '0;
        axi_rd_en = '0;
        wb_exp    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        do_swap();
        do_swap();
        rd(1, 40, 1'b0, 64'hAB);
        rd(1, 3, 1'b0, 64'd6);
        rd(1, 4, 1'b0, 64'd12);

        repeat (6) tick();
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("drained_ch%0d", c), 64'(exp_q[c].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
